decoder_scan: RTL and testbench

- Parametrised registered binary-to-one-hot decoder. Generalises the 2-to-4 combinational decoder to SEL_W-to-2^SEL_W.
- Adds an enable, a registered output, and an autonomous scan mode. In scan mode an internal sequencer walks the one-hot output across every line, holding each line for a programmable dwell.
- Drives row/digit strobes for multiplexed displays and test sweeps of select lines.

---
 rtl/decoder_scan_if.sv | 17 +
 rtl/decoder_scan.sv | 86 ++++++++
 tb/tb_decoder_scan.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_if.sv
// decoder_scan_if: control and one-hot output bundle between a decoder_scan and its driver
interface decoder_scan_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 2 ** SEL_W;
    logic             en;
    logic             mode;
    logic             in_valid;
    logic [SEL_W-1:0] sel;
    logic             start;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             busy;
    logic             done;
    modport master (output en, mode, in_valid, sel, start, input y, idx, busy, done);
    modport slave  (input en, mode, in_valid, sel, start, output y, idx, busy, done);
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with an autonomous dwell-timed line scan
module decoder_scan #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    decoder_scan_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(OUT_W - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_n;
    logic [OUT_W-1:0] y, y_n;
    logic [SEL_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy, busy_n;
    logic             done, done_n;

    assign bus.y    = y;
    assign bus.idx  = idx;
    assign bus.busy = busy;
    assign bus.done = done;

    // state and output registers; every output comes straight from a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= '0;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            y     <= y_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // next state: enable abort first, then direct decode / scan launch in IDLE, dwell stepping in SCAN
    always_comb begin
        state_n = state;
        y_n     = y;
        idx_n   = idx;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            y_n     = '0;
            cnt_n   = '0;
            busy_n  = 1'b0;
        end else if (state == IDLE) begin
            if (bus.mode && bus.start) begin
                state_n = SCAN;
                y_n     = OUT_W'(1);
                idx_n   = '0;
                cnt_n   = '0;
                busy_n  = 1'b1;
            end else if (!bus.mode && bus.in_valid) begin
                y_n   = OUT_W'(1) << bus.sel;
                idx_n = bus.sel;
            end
        end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + CNT_W'(1);
        end else if (idx != IDX_MAX) begin
            cnt_n = '0;
            idx_n = idx + SEL_W'(1);
            y_n   = y << 1;
        end else begin
            state_n = IDLE;
            y_n     = '0;
            cnt_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: scoreboard bench for a 4-line/dwell-4 and an 8-line/dwell-1 decoder_scan
module tb_decoder_scan;
    typedef struct packed {
        logic [7:0] y;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    decoder_scan_if #(.SEL_W(2)) ia ();
    decoder_scan_if #(.SEL_W(3)) ib ();

    decoder_scan #(.SEL_W(2), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    decoder_scan #(.SEL_W(3), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] y, input logic [2:0] idx, input logic busy, input logic done);
        mk = '{y: y, idx: idx, busy: busy, done: done};
    endfunction

    // queue the outputs expected after the coming edge, then return mid-low-phase
    task automatic tick(input bit b, input bit chk, input exp_t e);
        if (chk && b) qb.push_back(e);
        if (chk && !b) qa.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_y", 32'(ia.y), 32'(e.y[3:0]));
            check("a_idx", 32'(ia.idx), 32'(e.idx[1:0]));
            check("a_busy", 32'(ia.busy), 32'(e.busy));
            check("a_done", 32'(ia.done), 32'(e.done));
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_y", 32'(ib.y), 32'(e.y));
            check("b_idx", 32'(ib.idx), 32'(e.idx));
            check("b_busy", 32'(ib.busy), 32'(e.busy));
            check("b_done", 32'(ib.done), 32'(e.done));
        end
        if ($time > 5) begin
            check("b_onehot", 32'((ib.y & 8'(ib.y - 8'd1)) == 8'd0), 32'd1);
            if (ib.y != 8'd0) check("b_y_idx", 32'(ib.y), 32'(8'd1 << ib.idx));
        end
    end

    task automatic run_scan(input bit noisy, input bit hold);
        ia.start = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int d = 0; d < 4; d++) begin
                tick(0, 1, mk(8'(1 << l), 3'(l), 1'b1, 1'b0));
                ia.start = hold;
                if (noisy && l == 0 && d == 1) begin
                    ia.in_valid = 1'b1;
                    ia.sel = 2'd3;
                end
                if (noisy && l == 1 && d == 0) ia.mode = 1'b0;
                if (noisy && l == 1 && d == 2) ia.start = 1'b1;
                if (noisy && l == 2 && d == 0) begin
                    ia.in_valid = 1'b0;
                    ia.mode = 1'b1;
                end
            end
        end
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b1));
    endtask

    initial begin
        rst = 1'b0;
        ia.en = 1'b0; ia.mode = 1'b0; ia.in_valid = 1'b0; ia.sel = '0; ia.start = 1'b0;
        ib.en = 1'b0; ib.mode = 1'b0; ib.in_valid = 1'b0; ib.sel = '0; ib.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_y", 32'(ia.y), 32'd0);
        check("rst_busy", 32'(ia.busy), 32'd0);
        check("rst_idx", 32'(ia.idx), 32'd0);
        check("rst_done", 32'(ia.done), 32'd0);
        check("rst_b_y", 32'(ib.y), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        ia.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            ia.sel = 2'(s);
            ia.in_valid = 1'b1;
            tick(0, 1, mk(8'(1 << s), 3'(s), 1'b0, 1'b0));
            ia.in_valid = 1'b0;
            ia.sel = 2'(~s);
            tick(0, 1, mk(8'(1 << s), 3'(s), 1'b0, 1'b0));
        end
        ia.mode = 1'b1;
        ia.in_valid = 1'b1;
        ia.sel = 2'd0;
        tick(0, 1, mk(8'b1000, 3'd3, 1'b0, 1'b0));
        ia.en = 1'b0;
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        ia.mode = 1'b0;
        ia.sel = 2'd1;
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        ia.in_valid = 1'b0;
        ia.en = 1'b1;
        ia.mode = 1'b1;
        run_scan(0, 0);
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        run_scan(1, 0);
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        run_scan(0, 1);
        run_scan(0, 0);
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        ia.start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(0, 1, mk(8'(1 << (k / 4)), 3'(k / 4), 1'b1, 1'b0));
            ia.start = 1'b0;
        end
        ia.en = 1'b0;
        tick(0, 1, mk(8'd0, 3'd2, 1'b0, 1'b0));
        tick(0, 1, mk(8'd0, 3'd2, 1'b0, 1'b0));
        ia.en = 1'b1;
        run_scan(0, 0);
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        ia.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(0, 1, mk(8'(1 << (k / 4)), 3'(k / 4), 1'b1, 1'b0));
            ia.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("amid_y", 32'(ia.y), 32'd0);
        check("amid_busy", 32'(ia.busy), 32'd0);
        check("amid_idx", 32'(ia.idx), 32'd0);
        check("amid_done", 32'(ia.done), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_scan(0, 0);
        tick(0, 1, mk(8'd0, 3'd3, 1'b0, 1'b0));
        ib.en = 1'b1;
        ib.mode = 1'b1;
        ib.start = 1'b1;
        for (int l = 0; l < 8; l++) begin
            tick(1, 1, mk(8'(1 << l), 3'(l), 1'b1, 1'b0));
            ib.start = 1'b0;
        end
        tick(1, 1, mk(8'd0, 3'd7, 1'b0, 1'b1));
        tick(1, 1, mk(8'd0, 3'd7, 1'b0, 1'b0));
        tick(1, 0, mk(8'd0, 3'd0, 1'b0, 1'b0));
        check("sb_drain", 32'(qa.size() + qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
